// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Two-way round-robin arbiter that merges the ALU and LSU writeback streams
//   into the single register-file write port.
//
//   The handshake completes in the cycle where valid and ready are both high.
//   The accepted write appears on rf_we/rf_waddr/rf_wdata one cycle later.
//   Writes to x0 are accepted but never assert rf_we.
//
//   Optional scoreboard, built only when macro RF_SCOREBOARD_EN is defined:
//   - tracks which destination registers have a reservation pending;
//   - answers the decode stage's hazard queries.
//   Without the macro, rs1_busy/rs2_busy are constant 0.
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   alu_wb_*             - ALU writeback requester (index 0):
//                          valid/ready/addr/data
//   lsu_wb_*             - load writeback requester (index 1):
//                          valid/ready/addr/data
//   rf_we/waddr/wdata    - registered register-file write port
//   issue_valid/issue_rd - decode reserves a destination register
//   rs1/rs2_addr, *_busy - hazard query on source operands
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_wb_valid,
    output logic            alu_wb_ready,
    input  logic [4:0]      alu_wb_addr,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            lsu_wb_valid,
    output logic            lsu_wb_ready,
    input  logic [4:0]      lsu_wb_addr,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    // Requester that won the most recent accepted transfer: 0 = ALU, 1 = LSU.
    logic            r_last_grant;
    logic            w_alu_acc;
    logic            w_lsu_acc;
    logic            w_acc;
    logic [4:0]      w_acc_addr;
    logic [XLEN-1:0] w_acc_data;

    // A requester is ready unless the other one is contending and holds
    // priority. Only valids and the pointer matter, never addr or data.
    assign alu_wb_ready = !rst && (!lsu_wb_valid ||  r_last_grant);
    assign lsu_wb_ready = !rst && (!alu_wb_valid || !r_last_grant);

    assign w_alu_acc  = alu_wb_valid && alu_wb_ready;
    assign w_lsu_acc  = lsu_wb_valid && lsu_wb_ready;
    assign w_acc      = w_alu_acc || w_lsu_acc;
    assign w_acc_addr = w_lsu_acc ? lsu_wb_addr : alu_wb_addr;
    assign w_acc_data = w_lsu_acc ? lsu_wb_data : alu_wb_data;

    // Stage boundary: accepted transfer -> register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= '0;
        end else begin
            rf_we <= w_acc && (w_acc_addr != 5'd0);
            if (w_acc) begin
                r_last_grant <= w_lsu_acc;
                rf_waddr     <= w_acc_addr;
                rf_wdata     <= w_acc_data;
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_busy_set[issue_rd] = 1'b1;
        end
        if (w_acc) begin
            w_busy_clr[w_acc_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle re-reservation survives.
    // Bit 0 is masked because x0 can never be busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & 32'hFFFF_FFFE;
        end
    end

    assign rs1_busy = r_busy[rs1_addr];
    assign rs2_busy = r_busy[rs2_addr];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign rs1_busy    = 1'b0;
    assign rs2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
`ifdef RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_wb_valid = 1'b0;
    logic            alu_wb_ready;
    logic [4:0]      alu_wb_addr = '0;
    logic [XLEN-1:0] alu_wb_data = '0;
    logic            lsu_wb_valid = 1'b0;
    logic            lsu_wb_ready;
    logic [4:0]      lsu_wb_addr = '0;
    logic [XLEN-1:0] lsu_wb_data = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic [4:0]      rs1_addr = '0;
    logic [4:0]      rs2_addr = '0;
    logic            rs1_busy;
    logic            rs2_busy;

    regfile_wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_last = 1;       // who won last: 0 ALU, 1 LSU
    bit [31:0]       m_busy = '0;
    logic [4:0]      m_waddr = '0;
    logic [XLEN-1:0] m_wdata = '0;
    bit              m_hold_ok = 1'b0; // write port contents are known
    bit              acc_alu = 1'b0;
    bit              acc_lsu = 1'b0;
    logic [4:0]      seq [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check readys mid-cycle, then check the registered outputs
    // and scoreboard answers just after the edge.
    task automatic cycle();
        bit ga, gl, we_e;
        logic [4:0] a;
        @(negedge clk);
        if (rst) begin
            ga = 1'b0;
            gl = 1'b0;
            chk("rst_alu_ready", 32'(alu_wb_ready), 32'd0);
            chk("rst_lsu_ready", 32'(lsu_wb_ready), 32'd0);
        end else begin
            if (alu_wb_valid && lsu_wb_valid) begin
                ga = (m_last == 1);
                gl = !ga;
            end else begin
                ga = alu_wb_valid;
                gl = lsu_wb_valid;
            end
            if (alu_wb_valid) chk("alu_ready", 32'(alu_wb_ready), 32'(ga));
            if (lsu_wb_valid) chk("lsu_ready", 32'(lsu_wb_ready), 32'(gl));
        end
        @(posedge clk);
        #1;
        we_e = 1'b0;
        if (rst) begin
            m_last = 1; m_busy = '0; m_waddr = '0; m_wdata = '0; m_hold_ok = 1'b1;
        end else begin
            if (ga || gl) begin
                a         = ga ? alu_wb_addr : lsu_wb_addr;
                m_waddr   = a;
                m_wdata   = ga ? alu_wb_data : lsu_wb_data;
                we_e      = (a != 5'd0);
                m_hold_ok = we_e;
                m_last    = gl ? 1 : 0;
                m_busy[a] = 1'b0;
            end
            if (SB && issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
        m_busy[0] = 1'b0;
        chk("rf_we", 32'(rf_we), 32'(we_e));
        if (m_hold_ok) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        chk("rs1_busy", 32'(rs1_busy), SB ? 32'(m_busy[rs1_addr]) : 32'd0);
        chk("rs2_busy", 32'(rs2_busy), SB ? 32'(m_busy[rs2_addr]) : 32'd0);
        acc_alu = ga;
        acc_lsu = gl;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_we", 32'(rf_we), 32'd0);
        chk("reset_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);
        rst = 1'b0;

        // Lone ALU request
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
        cycle();
        chk("single_alu_acc", 32'(acc_alu), 32'd1);
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        alu_wb_valid = 1'b0;
        cycle();
        chk("idle_we", 32'(rf_we), 32'd0);
        chk("idle_hold_waddr", 32'(rf_waddr), 32'd5);

        // Tie alternation from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd1; alu_wb_data = 32'h1111;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd2; lsu_wb_data = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = rf_waddr;
        end
        chk("rr_0", 32'(seq[0]), 32'd1);
        chk("rr_1", 32'(seq[1]), 32'd2);
        chk("rr_2", 32'(seq[2]), 32'd1);
        chk("rr_3", 32'(seq[3]), 32'd2);

        // x0 write from LSU, then a tie must go to the ALU
        alu_wb_valid = 1'b0;
        lsu_wb_addr = 5'd0; lsu_wb_data = 32'h1234;
        cycle();
        chk("x0_lsu_acc", 32'(acc_lsu), 32'd1);
        chk("x0_we", 32'(rf_we), 32'd0);
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 32'h3333;
        lsu_wb_addr = 5'd4; lsu_wb_data = 32'h4444;
        cycle();
        chk("after_x0_alu_wins", 32'(acc_alu), 32'd1);
        chk("after_x0_waddr", 32'(rf_waddr), 32'd3);
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        cycle();

`ifdef RF_SCOREBOARD_EN
        // Scoreboard set / clear / set-wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle();
        issue_valid = 1'b0; rs1_addr = 5'd7;
        cycle();
        chk("sb_busy_set", 32'(rs1_busy), 32'd1);
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd7; alu_wb_data = 32'h77;
        cycle();
        chk("sb_busy_clr", 32'(rs1_busy), 32'd0);
        issue_valid = 1'b1;
        cycle();
        chk("sb_set_wins", 32'(rs1_busy), 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd9; alu_wb_valid = 1'b0; rs2_addr = 5'd9;
        cycle();
        issue_valid = 1'b0;
        chk("sb_busy9", 32'(rs2_busy), 32'd1);
`endif

        // Reset mid-stream with both valid
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd10; alu_wb_data = 32'hA;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd11; lsu_wb_data = 32'hB;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_busy1", 32'(rs1_busy), 32'd0);
        chk("midrst_busy2", 32'(rs2_busy), 32'd0);
        cycle();
        chk("midrst_alu_first", 32'(acc_alu), 32'd1);

        // Randomized traffic; requesters hold their request until accepted
        for (int i = 0; i < 500; i++) begin
            if (!alu_wb_valid || acc_alu) begin
                alu_wb_valid = ($urandom_range(0, 2) != 0);
                alu_wb_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                alu_wb_data  = $urandom;
            end
            if (!lsu_wb_valid || acc_lsu) begin
                lsu_wb_valid = ($urandom_range(0, 2) != 0);
                lsu_wb_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                lsu_wb_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom);
            rs1_addr    = 5'($urandom);
            rs2_addr    = 5'($urandom);
            rst         = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, write-data width; matches register file data width.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: alu_wb_valid in 1, alu_wb_ready out 1, alu_wb_addr in 5, alu_wb_data in XLEN; the ALU writeback requester (index 0).
REQ-005 SHALL have ports: lsu_wb_valid in 1, lsu_wb_ready out 1, lsu_wb_addr in 5, lsu_wb_data in XLEN; the load writeback requester (index 1).
REQ-006 SHALL have ports: rf_we out 1, rf_waddr out 5, rf_wdata out XLEN; these drive the register file readWrite, addr_write and write_data inputs.
REQ-007 SHALL have ports: issue_valid in 1, issue_rd in 5; the decode stage reserves a destination register.
REQ-008 SHALL have ports: rs1_addr in 5, rs2_addr in 5, rs1_busy out 1, rs2_busy out 1; the hazard query for the source operands.

Function
REQ-009 SHALL accept a request when valid and ready are both high in the same cycle.
REQ-010 SHALL accept at most one request per cycle.
REQ-011 SHALL drive ready combinationally from the valids and the grant pointer; ready SHALL NOT depend on data or addr.
REQ-012 SHALL grant a single valid requester immediately.
REQ-013 SHALL arbitrate round-robin when both requesters are valid: grant the requester not granted last.
REQ-014 SHALL update the last_grant pointer only on an accepted transfer.
REQ-015 SHALL register an accepted transfer to rf_we/rf_waddr/rf_wdata on the next posedge (latency 1 cycle); rf_we SHALL be high for exactly one cycle per accepted non-x0 transfer.
REQ-016 SHALL accept a request with addr 0 normally (ready asserted, pointer updated), but SHALL hold rf_we low for it.
REQ-017 SHALL hold rf_we low with rf_waddr/rf_wdata at their previous values in a cycle following no acceptance.
REQ-018 SHALL keep a requester's ready low while the other requester holds the grant; the requester must hold valid, addr and data stable until accepted.
REQ-019 SHALL maintain busy[31:0] (scoreboard, see REQ-026): issue_valid with issue_rd≠0 sets busy[issue_rd] at the next posedge.
REQ-020 SHALL clear busy[addr] at the posedge on which a write to addr is accepted; if a set and a clear of the same register occur in the same cycle, the set SHALL win.
REQ-021 SHALL make busy[0] constantly 0.
REQ-022 SHALL produce rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr] combinationally, with no forwarding of a same-cycle set or clear.

Reset
REQ-023 SHALL, with rst high at posedge, set rf_we=0, rf_waddr=0, rf_wdata=0 and busy=0.
REQ-024 SHALL, with rst high at posedge, set last_grant=1 (LSU), so that the ALU wins the first tie.
REQ-025 SHALL, while rst is high, force both readys low and ignore issue_valid; a transfer presented during reset is not accepted and produces no write after reset.

Configuration
REQ-026 SHALL compile busy, rs1_busy, rs2_busy and the issue logic only when macro RF_SCOREBOARD_EN is defined; without it, rs1_busy=rs2_busy=0 constantly, issue_valid/issue_rd/rs*_addr are ignored, and arbitration is identical.

Verification
REQ-027 SHALL verify: only alu valid, addr 5, data 0xDEADBEEF -> alu ready same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-028 SHALL verify: after reset, both valid held 4 cycles (alu addr 1, lsu addr 2) -> grants alternate ALU, LSU, ALU, LSU; rf_waddr sequence 1,2,1,2.
REQ-029 SHALL verify: lsu valid with addr 0, data 0x1234 -> lsu ready=1; next cycle rf_we=0; the following tie grants the ALU.
REQ-030 SHALL verify (RF_SCOREBOARD_EN): issue rd=7, then rs1_addr=7 -> rs1_busy=1; alu writes addr 7 -> rs1_busy=0 the cycle after acceptance; issue rd=7 in the same cycle as the accept -> rs1_busy stays 1.
REQ-031 SHALL verify: rst asserted for 1 cycle mid-stream with both valid -> readys low in the reset cycle, rf_we=0 and busy=0 the next cycle, and the ALU is granted first afterwards.
